// File: rtl/sr_readback_pkg.sv
// sr_readback_pkg: shared shift-register definitions used by the write-side
// controller and the readback block (FSM encodings, error counter width).
package sr_readback_pkg;
    localparam int ERR_W = 16;
    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_SKIP  = 4'b0010;
    localparam logic [3:0] ST_SHIFT = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b1000;
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/sr_readback.sv
// sr_readback: serially captures a shift-register readback into a parallel word,
// compares it with the word written earlier and counts mismatches.
module sr_readback
    import sr_readback_pkg::*;
#(
    parameter int DATA_WIDTH      = 170,
    parameter int CNT_WIDTH       = 8,
    parameter int SHIFT_DIRECTION = 1,
    parameter int SAMPLE_DELAY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sr_din,
    input  logic [DATA_WIDTH-1:0] expected,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  match,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  bit_count,
    output logic [ERR_W-1:0]      err_count
);
    localparam int SKW = (SAMPLE_DELAY > 1) ? $clog2(SAMPLE_DELAY) : 1;
    localparam logic [SKW-1:0] SKIP_LAST = SKW'(SAMPLE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [3:0] ST_FIRST = (SAMPLE_DELAY > 0) ? ST_SKIP : ST_SHIFT;

    if (DATA_WIDTH >= (1 << CNT_WIDTH)) begin : g_width_chk
        $error("sr_readback: DATA_WIDTH must be smaller than 2**CNT_WIDTH");
    end

    logic [3:0]            r_state;
    logic [SKW-1:0]        r_skip;
    logic [CNT_WIDTH-1:0]  r_bc;
    logic [DATA_WIDTH-1:0] r_cap;
    logic [DATA_WIDTH-1:0] r_exp;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic                  r_match;
    logic [ERR_W-1:0]      r_err;
    logic [DATA_WIDTH-1:0] w_cap_next;
    logic                  w_eq;

    // Direction 1 puts the first bit in the MSB, direction 0 in the LSB.
    assign w_cap_next = (SHIFT_DIRECTION != 0) ? {r_cap[DATA_WIDTH-2:0], sr_din}
                                               : {sr_din, r_cap[DATA_WIDTH-1:1]};
    assign w_eq = (r_cap == r_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
            r_bc    <= '0;
            r_cap   <= '0;
            r_exp   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_err   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_exp   <= expected;
                    r_bc    <= '0;
                    r_skip  <= '0;
                    r_state <= ST_FIRST;
                end
            end else if (r_state == ST_SKIP) begin
                if (r_skip == SKIP_LAST) r_state <= ST_SHIFT;
                else r_skip <= r_skip + 1'b1;
            end else if (r_state == ST_SHIFT) begin
                r_cap <= w_cap_next;
                r_bc  <= r_bc + 1'b1;
                if (r_bc == LAST_BIT) r_state <= ST_DONE;
            end else if (r_state == ST_DONE) begin
                r_dout  <= r_cap;
                r_match <= w_eq;
                r_valid <= 1'b1;
                if (!w_eq) r_err <= sat_inc(r_err);
                r_state <= ST_IDLE;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign dout      = r_dout;
    assign valid     = r_valid;
    assign match     = r_match;
    assign busy      = (r_state != ST_IDLE);
    assign bit_count = r_bc;
    assign err_count = r_err;
endmodule

// File: doc/sr_readback.md
SR_READBACK -- requirements
Module: sr_readback

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 170, which sets the number of bits captured per readback.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, which sets the width of the bit counter and the bit_count output.
REQ-003 SHALL have parameter SHIFT_DIRECTION, default 1; 1 means the first captured bit lands in the MSB, 0 means it lands in the LSB.
REQ-004 SHALL have parameter SAMPLE_DELAY, default 2, which sets the number of idle cycles between start and the first capture (0 allowed).
REQ-005 SHALL have port clk, input, width 1: clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, width 1: request one readback.
REQ-008 SHALL have port sr_din, input, width 1: serial bit from the shift-register output.
REQ-009 SHALL have port expected, input, width DATA_WIDTH: word written earlier, used for comparison.
REQ-010 SHALL have port dout, output, width DATA_WIDTH: captured parallel word.
REQ-011 SHALL have port valid, output, width 1: one-cycle pulse when dout and match are updated.
REQ-012 SHALL have port match, output, width 1: 1 when the captured word equals expected.
REQ-013 SHALL have port busy, output, width 1: high while the state is not IDLE.
REQ-014 SHALL have port bit_count, output, width CNT_WIDTH: bits captured so far in the current readback.
REQ-015 SHALL have port err_count, output, width 16: saturating count of mismatched readbacks.

Function
REQ-016 SHALL implement a one-hot FSM with states IDLE, SKIP, SHIFT and DONE.
REQ-017 In IDLE with start=1 at edge t0, SHALL latch expected into an internal register and enter SKIP (SAMPLE_DELAY>0) or SHIFT (SAMPLE_DELAY=0).
REQ-018 SKIP SHALL last exactly SAMPLE_DELAY cycles, counted by a skip counter cleared on entry, then enter SHIFT.
REQ-019 SHIFT SHALL sample sr_din on every edge, on edges t0+SAMPLE_DELAY+1 through t0+SAMPLE_DELAY+DATA_WIDTH, and increment bit_count on each capture.
REQ-020 When SHIFT_DIRECTION=1, SHALL shift the capture register left and insert sr_din at bit 0; when SHIFT_DIRECTION=0, SHALL shift it right and insert sr_din at bit DATA_WIDTH-1.
REQ-021 SHALL leave SHIFT for DONE on the edge that captures bit number DATA_WIDTH.
REQ-022 At edge t0+SAMPLE_DELAY+DATA_WIDTH+1 (the DONE edge), SHALL load dout from the capture register, set match to (capture == latched expected), pulse valid high for one cycle and return to IDLE.
REQ-023 On each mismatch at the DONE edge, SHALL increment err_count, holding it at 16'hFFFF (no wrap).
REQ-024 SHALL ignore start while busy=1; a request is neither queued nor restarted.
REQ-025 SHALL accept start in the cycle immediately after valid, giving back-to-back readbacks.
REQ-026 dout and match SHALL hold their values until the next DONE edge; changes to the expected port after t0 SHALL have no effect.
REQ-027 bit_count SHALL clear on entry to SKIP/SHIFT from IDLE and hold at DATA_WIDTH in DONE and IDLE until the next start.
REQ-028 SHALL require DATA_WIDTH < 2**CNT_WIDTH; this is checked by an elaboration-time assertion.

Reset
REQ-029 Asserting rst SHALL immediately force: state IDLE, dout 0, valid 0, match 0, busy 0, bit_count 0, err_count 0, capture register 0, latched expected 0.
REQ-030 When rst asserts mid-readback, SHALL abandon the capture with no valid pulse and no err_count change.
REQ-031 After rst deasserts, SHALL accept a start on the first rising edge.

Structure
REQ-032 The state encodings and a package constant for the err_count width (16) SHALL live in the shared shift-register package used by the write-side controller.
REQ-033 SHALL be a single module with no sub-modules; the capture shifter and the comparator are inline.

Verification (DATA_WIDTH=8, SAMPLE_DELAY=2, CNT_WIDTH=4 unless stated)
REQ-034 The bench SHALL cover: SHIFT_DIRECTION=1, start at t0, serial stream 1,0,1,1,0,0,1,0 on capture edges, expected=8'hB2 -> dout=8'hB2, match=1, valid at edge t0+11 only, err_count=0.
REQ-035 The bench SHALL cover: SHIFT_DIRECTION=0, same stream, expected=8'h4D -> dout=8'h4D, match=1.
REQ-036 The bench SHALL cover: stream giving 8'hB3 with expected=8'hB2 -> match=0 and err_count=1; with err_count preset near 16'hFFFF, repeated mismatches -> err_count stays at 16'hFFFF.
REQ-037 The bench SHALL cover: start pulsed again at t0+4 -> ignored, exactly one valid pulse; start the cycle after valid -> second readback completes 11 cycles later.
REQ-038 The bench SHALL cover: rst at t0+6 -> all outputs 0 immediately, no valid pulse; a new start then produces a correct result.
REQ-039 The bench SHALL cover: SAMPLE_DELAY=0 with DATA_WIDTH=170, CNT_WIDTH=8 -> capture edges t0+1..t0+170, valid at t0+171, and a random pattern matches.
